ddr3_stream_writer: RTL and testbench
=====================================

DDR3_STREAM_WRITER -- requirements
Module: ddr3_stream_writer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32, idle cycles before a partial buffer is flushed; legal range 1..65535.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  32  upstream word.
REQ-006 in_last  input  1  final word of a transfer; qualified by in_valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 pp_ready  input  2  ping-pong FIFO write-side buffer available, one bit per buffer.
REQ-009 pp_activate  output  2  buffer ownership, at most one bit set.
REQ-010 pp_size  input  24  capacity in words of an owned buffer.
REQ-011 pp_strobe  output  1  write strobe into the owned buffer.
REQ-012 pp_data  output  32  word written with pp_strobe.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 words_total  output  32  count of words strobed since reset; wraps modulo 2^32.

Function
REQ-015 States: IDLE, FILL, RELEASE, GUARD.
REQ-016 IDLE: if pp_ready nonzero, set pp_activate to bit0 when pp_ready[0] else bit1, clear fill count, go FILL; pp_ready==3 selects buffer 0.
REQ-017 in_ready = (state==FILL) && (fill count < pp_size) && no release pending; combinational.
REQ-018 Accept = in_valid && in_ready; next cycle pp_strobe=1, pp_data=accepted word, fill count+1, words_total+1 (latency 1).
REQ-019 pp_strobe high only while pp_activate nonzero; never more than pp_size strobes per ownership.
REQ-020 FILL -> RELEASE when accepted word has in_last=1, or accepted word makes fill count equal pp_size.
REQ-021 RELEASE: drive pp_activate=0 on the cycle after the final strobe; go GUARD.
REQ-022 GUARD: one cycle, no acquisition (covers ready-bit latency); then IDLE.
REQ-023 Buffer never released with fill count 0; in_last on an empty buffer is impossible, since the last word itself is counted.
REQ-024 in_valid during IDLE/RELEASE/GUARD is stalled (in_ready=0); no word is dropped or duplicated.
REQ-025 fill count is 24 bits; pp_size of 0 while owned: in_ready stays 0, release occurs only via timeout path, never with 0 words.
REQ-026 Simultaneous in_last and buffer-full on one word: single release, no extra empty ownership.

Reset
REQ-027 On rst: state IDLE, pp_activate 0, pp_strobe 0, pp_data 0, fill count 0, timeout counter 0, words_total 0, busy 0, in_ready 0.
REQ-028 rst mid-FILL abandons the owned buffer immediately (pp_activate 0 next cycle); the FIFO shares rst and discards contents.

Configuration
REQ-029 Macro DDR3_STREAM_WRITER_TIMEOUT_EN defined: in FILL with fill count>0, 16-bit counter increments on each cycle without accept, clears on accept; at TIMEOUT_CYCLES go RELEASE.
REQ-030 Macro undefined: no timeout counter; partial buffers released only by in_last or full.

Verification
REQ-031 pp_size=64, pp_ready=01, stream 64 words 0..63, no in_last -> 64 strobes on buffer 0, pp_activate 0 after strobe 64, in_ready 0 for the RELEASE and GUARD cycles.
REQ-032 pp_ready=11, 3 words with in_last on word 3 -> buffer 0 selected, exactly 3 strobes, release, words_total=3.
REQ-033 Macro defined, TIMEOUT_CYCLES=8, send 5 words then idle -> release exactly 8 idle cycles after word 5; macro undefined -> pp_activate held indefinitely.
REQ-034 pp_ready=00 for 20 cycles with in_valid=1 -> in_ready 0 throughout, no strobe; pp_ready=10 -> buffer 1 acquired, first word strobed.
REQ-035 Assert rst during FILL after 10 words -> next cycle all outputs at reset values, words_total=0.
REQ-036 Random in_valid gaps, 1000 words, pp_size=64 -> pp_data sequence equals input order, no buffer exceeds 64 strobes, words_total=1000.

Source files
------------

// File: rtl/ddr3_stream_writer_if.sv
// Handshake and ping-pong FIFO write-port bundle for ddr3_stream_writer.
// master = the writer block, slave = upstream source plus FIFO side.
interface ddr3_stream_writer_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [1:0]  pp_ready;
  logic [1:0]  pp_activate;
  logic [23:0] pp_size;
  logic        pp_strobe;
  logic [31:0] pp_data;
  logic        busy;
  logic [31:0] words_total;

  modport master (
    input  in_valid, in_data, in_last, pp_ready, pp_size,
    output in_ready, pp_activate, pp_strobe, pp_data, busy, words_total
  );

  modport slave (
    output in_valid, in_data, in_last, pp_ready, pp_size,
    input  in_ready, pp_activate, pp_strobe, pp_data, busy, words_total
  );
endinterface

// File: rtl/ddr3_stream_writer.sv
// Streams 32-bit words into a ping-pong FIFO, owning one buffer at a time.
// Define DDR3_STREAM_WRITER_TIMEOUT_EN to flush partial buffers after TIMEOUT_CYCLES idle cycles.
module ddr3_stream_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input logic                  clk,
  input logic                  rst,
  ddr3_stream_writer_if.master bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] GUARD   = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ddr3_stream_writer: TIMEOUT_CYCLES must be within 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  pp_activate_q, pp_activate_d;
  logic        pp_strobe_q, pp_strobe_d;
  logic [31:0] pp_data_q, pp_data_d;
  logic [23:0] fill_q, fill_d;
  logic [31:0] words_total_q, words_total_d;
  logic        in_ready;
  logic        accept;
`ifdef DDR3_STREAM_WRITER_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d       = state_q;
    pp_activate_d = pp_activate_q;
    pp_strobe_d   = 1'b0;
    pp_data_d     = pp_data_q;
    fill_d        = fill_q;
    words_total_d = words_total_q;
    // Pending release is expressed by RELEASE/GUARD, so FILL alone gates acceptance.
    in_ready      = (state_q == FILL) && (fill_q < bus.pp_size);
    accept        = bus.in_valid && in_ready;

    if (accept) begin
      pp_strobe_d   = 1'b1;
      pp_data_d     = bus.in_data;
      fill_d        = fill_q + 24'd1;
      words_total_d = words_total_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.pp_ready != '0) begin
          pp_activate_d = bus.pp_ready[0] ? 2'b01 : 2'b10;
          fill_d        = '0;
          state_d       = FILL;
        end
      end
      FILL: begin
        if (accept && (bus.in_last || fill_d == bus.pp_size)) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        pp_activate_d = '0;
        state_d       = GUARD;
      end
      default: state_d = IDLE;
    endcase

`ifdef DDR3_STREAM_WRITER_TIMEOUT_EN
    // Counter only runs on a non-empty buffer, so a timeout never releases zero words.
    idle_d = '0;
    if (state_q == FILL && !accept && fill_q != '0) begin
      idle_d = idle_q + 16'd1;
      if (idle_d == 16'(TIMEOUT_CYCLES)) begin
        state_d = RELEASE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pp_activate_q <= '0;
      pp_strobe_q   <= 1'b0;
      pp_data_q     <= '0;
      fill_q        <= '0;
      words_total_q <= '0;
`ifdef DDR3_STREAM_WRITER_TIMEOUT_EN
      idle_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pp_activate_q <= pp_activate_d;
      pp_strobe_q   <= pp_strobe_d;
      pp_data_q     <= pp_data_d;
      fill_q        <= fill_d;
      words_total_q <= words_total_d;
`ifdef DDR3_STREAM_WRITER_TIMEOUT_EN
      idle_q        <= idle_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.pp_activate = pp_activate_q;
  assign bus.pp_strobe   = pp_strobe_q;
  assign bus.pp_data     = pp_data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.words_total = words_total_q;
endmodule

// File: tb/tb_ddr3_stream_writer.sv
// Self-checking bench for ddr3_stream_writer: directed scenarios plus a randomized
// stream checked against a word-order scoreboard and per-ownership strobe counts.
module tb_ddr3_stream_writer;
  logic clk;
  logic rst;

  ddr3_stream_writer_if bus ();

  ddr3_stream_writer #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_total;
  int unsigned own_cnt;
  int unsigned last_own;
  logic        rdy_s, acc_s, rst_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard view: every accepted word must appear once, in order, on an owned buffer.
  task automatic monitor();
    chk("words_total", bus.words_total, exp_total);
    chk("activate_onehot", 32'(bus.pp_activate == 2'b11), 32'd0);
    if (bus.pp_strobe) begin
      own_cnt++;
      chk("strobe_owned", 32'(bus.pp_activate != 2'b00), 32'd1);
      chk("strobe_limit", 32'(own_cnt <= 32'(bus.pp_size)), 32'd1);
      if (exp_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
      else chk("pp_data", bus.pp_data, exp_q.pop_front());
    end
    if (bus.pp_activate == 2'b00 && own_cnt != 0) begin
      last_own = own_cnt;
      own_cnt  = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rdy_s = bus.in_ready;
    acc_s = bus.in_valid && bus.in_ready;
    rst_s = rst;
    if (acc_s && !rst_s) begin
      exp_q.push_back(bus.in_data);
      exp_total = exp_total + 32'd1;
    end
    @(posedge clk);
    #1;
    if (rst_s) begin
      exp_q.delete();
      exp_total = '0;
      own_cnt   = 0;
    end else begin
      monitor();
    end
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_s && n < 300);
    if (!acc_s) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.pp_ready = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int unsigned acc_cnt;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.pp_ready = 2'b00;
    bus.pp_size  = 24'd64;
    exp_total    = '0;
    own_cnt      = 0;
    last_own     = 0;

    // Reset values
    tick();
    tick();
    chk("rst_activate", 32'(bus.pp_activate), 32'd0);
    chk("rst_strobe", 32'(bus.pp_strobe), 32'd0);
    chk("rst_data", bus.pp_data, 32'd0);
    chk("rst_total", bus.words_total, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;

    // No buffer available: stall, then acquire buffer 1
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A5_0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noready_in_ready", 32'(rdy_s), 32'd0);
      chk("noready_strobe", 32'(bus.pp_strobe), 32'd0);
    end
    bus.pp_ready = 2'b10;
    send_word(32'hA5A5_0001, 1'b1);
    chk("buf1_activate", 32'(bus.pp_activate), 32'd2);
    chk("buf1_strobe", 32'(bus.pp_strobe), 32'd1);
    bus.pp_ready = 2'b00;
    repeat (3) tick();
    chk("buf1_released", 32'(bus.pp_activate), 32'd0);
    chk("buf1_idle", 32'(bus.busy), 32'd0);
    chk("buf1_count", last_own, 32'd1);

    // Both ready selects buffer 0; in_last on word 3
    do_reset();
    bus.pp_ready = 2'b11;
    send_word($urandom, 1'b0);
    chk("both_select_buf0", 32'(bus.pp_activate), 32'd1);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    bus.pp_ready = 2'b00;
    tick();
    tick();
    chk("last3_released", 32'(bus.pp_activate), 32'd0);
    chk("last3_strobes", last_own, 32'd3);
    chk("last3_total", bus.words_total, 32'd3);

    // Full buffer of 64 words without in_last
    do_reset();
    bus.pp_ready = 2'b01;
    for (int i = 0; i < 64; i++) send_word(32'(i), 1'b0);
    chk("full_last_strobe", 32'(bus.pp_strobe), 32'd1);
    chk("full_last_data", bus.pp_data, 32'd63);
    chk("full_still_owned", 32'(bus.pp_activate), 32'd1);
    chk("release_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd64;
    bus.in_last  = 1'b1;
    tick();
    chk("release_no_accept", 32'(acc_s), 32'd0);
    chk("full_released", 32'(bus.pp_activate), 32'd0);
    chk("full_strobes", last_own, 32'd64);
    tick();
    chk("guard_in_ready", 32'(rdy_s), 32'd0);
    send_word(32'd64, 1'b1);
    bus.pp_ready = 2'b00;
    repeat (3) tick();
    chk("stalled_word_kept", last_own, 32'd1);

    // Last word coincides with buffer full
    do_reset();
    bus.pp_size  = 24'd4;
    bus.pp_ready = 2'b01;
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    bus.pp_ready = 2'b00;
    tick();
    chk("dual_released", 32'(bus.pp_activate), 32'd0);
    chk("dual_strobes", last_own, 32'd4);
    repeat (4) tick();
    chk("dual_idle", 32'(bus.busy), 32'd0);

    // Zero-capacity buffer: held, never accepts
    do_reset();
    bus.pp_size  = 24'd0;
    bus.pp_ready = 2'b01;
    bus.in_valid = 1'b1;
    repeat (30) tick();
    chk("size0_in_ready", 32'(rdy_s), 32'd0);
    chk("size0_held", 32'(bus.pp_activate), 32'd1);
    chk("size0_total", bus.words_total, 32'd0);
    bus.pp_size = 24'd64;

    // Reset mid-fill after 10 words
    do_reset();
    bus.pp_ready = 2'b01;
    for (int i = 0; i < 10; i++) send_word($urandom, 1'b0);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst_activate", 32'(bus.pp_activate), 32'd0);
    chk("midrst_strobe", 32'(bus.pp_strobe), 32'd0);
    chk("midrst_data", bus.pp_data, 32'd0);
    chk("midrst_total", bus.words_total, 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;

    // Partial buffer with upstream gone idle
    do_reset();
    bus.pp_ready = 2'b01;
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
    bus.pp_ready = 2'b00;
`ifdef DDR3_STREAM_WRITER_TIMEOUT_EN
    n = 0;
    while (bus.pp_activate != 2'b00 && n < 40) begin
      tick();
      n++;
    end
    // 8 idle cycles reach RELEASE; ownership drops one cycle later
    chk("timeout_drop_cycle", 32'(n), 32'd9);
    chk("timeout_strobes", last_own, 32'd5);
`else
    repeat (100) tick();
    chk("no_timeout_held", 32'(bus.pp_activate), 32'd1);
    chk("no_timeout_busy", 32'(bus.busy), 32'd1);
    send_word($urandom, 1'b1);
    tick();
    chk("no_timeout_strobes", last_own, 32'd6);
`endif

    // Randomized stream of 1000 words
    do_reset();
    bus.pp_size = 24'd64;
    acc_cnt = 0;
    n = 0;
    while (acc_cnt < 1000 && n < 30000) begin
      bus.pp_ready = 2'($urandom_range(1, 3));
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_data  = $urandom;
      bus.in_last  = ($urandom_range(0, 39) == 0);
      tick();
      if (acc_s) acc_cnt++;
      n++;
    end
    chk("random_accepted", acc_cnt, 32'd1000);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.pp_ready = 2'b00;
    repeat (5) tick();
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    chk("random_total", bus.words_total, 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
